// File: rtl/ed_sweep_pkg.sv
// Shared types and constants for the ED sweep sequencer.
package ed_sweep_pkg;

  localparam int MAX_NODES = 16;
  localparam int NODE_W    = 4;
  localparam int ED_W      = 32;

  // Value the two-minimum finder holds in a slot that has not been filled.
  localparam logic [31:0] ED_SENTINEL = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    FEED,
    CAPTURE,
    DONE
  } state_t;

  // Captured result of one sweep.
  typedef struct packed {
    logic [31:0] min1_node;
    logic [31:0] min2_node;
    logic [31:0] min1_ed;
    logic [31:0] min2_ed;
    logic        single;
  } res_t;

endpackage

// File: rtl/sweep_counter.sv
// Node index counter for one sweep: loads 0 with the sweep length,
// steps once per fed node and flags the final index (N-1).
module sweep_counter #(
  parameter int NODE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [NODE_W:0]   num_nodes,
  output logic [NODE_W-1:0] cnt,
  output logic              last
);

  logic [NODE_W-1:0] last_idx;

  // Index register and latched last index (N-1); legal N always fits NODE_W bits once decremented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      last_idx <= '0;
    end else if (load) begin
      cnt      <= '0;
      last_idx <= NODE_W'(num_nodes - 1'b1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == last_idx);

endmodule

// File: rtl/ed_sweep_ctrl.sv
// Sweep sequencer: requests the ED of nodes 0..N-1, streams each ED/node
// pair into the external two-minimum finder, captures the finder's result
// and holds it on a valid/ready port.
//
// Handshakes:
//   ed_req/ed_ack : ed_req and ed_node stay stable until ed_ack is sampled
//                   high on a rising edge (same-cycle ack is allowed).
//   res_valid/res_ready : res_* and res_valid stay stable until res_ready is
//                   sampled high while res_valid is high.
module ed_sweep_ctrl #(
  parameter int MAX_NODES = 16,
  parameter int NODE_W    = 4,
  parameter int ED_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NODE_W:0]   num_nodes,
  output logic              busy,
  output logic              cfg_err,
  output logic              ed_req,
  output logic [NODE_W-1:0] ed_node,
  input  logic              ed_ack,
  input  logic [ED_W-1:0]   ed_value,
  output logic              mf_enable,
  output logic [31:0]       mf_node,
  output logic [31:0]       mf_ed,
  input  logic [31:0]       mf_min1_node,
  input  logic [31:0]       mf_min2_node,
  input  logic [31:0]       mf_min1_ed,
  input  logic [31:0]       mf_min2_ed,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_min1_node,
  output logic [31:0]       res_min2_node,
  output logic [31:0]       res_min1_ed,
  output logic [31:0]       res_min2_ed,
  output logic              res_single
);

  import ed_sweep_pkg::*;

  localparam logic [NODE_W:0] MAX_N = (NODE_W+1)'(MAX_NODES);

  state_t            state;
  state_t            state_nxt;
  logic [NODE_W-1:0] cnt;
  logic              last;
  logic              legal;
  logic              cnt_load;
  logic              cnt_inc;
  res_t              res_q;

  assign legal    = (num_nodes != '0) && (num_nodes <= MAX_N);
  assign cnt_load = (state == IDLE) && start && legal;
  assign cnt_inc  = (state == FEED) && !last;

  sweep_counter #(
    .NODE_W (NODE_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .inc       (cnt_inc),
    .num_nodes (num_nodes),
    .cnt       (cnt),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the state-decoded request outputs.
  always_comb begin
    state_nxt = state;
    ed_req    = 1'b0;
    case (state)
      IDLE: begin
        if (start && legal) state_nxt = ISSUE;
      end
      ISSUE: begin
        ed_req = 1'b1;
        if (ed_ack) state_nxt = FEED;
      end
      FEED: begin
        state_nxt = last ? CAPTURE : ISSUE;
      end
      CAPTURE: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy    = (state != IDLE);
  assign ed_node = cnt;

  // Config error pulse: only a start seen in IDLE with an out-of-range length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !legal;
    end
  end

  // Finder feed: a new ED/node pair per ack; enable falls at capture so the finder clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mf_enable <= 1'b0;
      mf_node   <= '0;
      mf_ed     <= '0;
    end else if ((state == ISSUE) && ed_ack) begin
      mf_enable <= 1'b1;
      mf_node   <= 32'(cnt);
      mf_ed     <= 32'(ed_value);
    end else if (state == CAPTURE) begin
      mf_enable <= 1'b0;
    end
  end

  // Result register and valid flag; fields hold from capture until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_valid <= 1'b0;
    end else if (state == CAPTURE) begin
      res_q.min1_node <= mf_min1_node;
      res_q.min2_node <= mf_min2_node;
      res_q.min1_ed   <= mf_min1_ed;
      res_q.min2_ed   <= mf_min2_ed;
      res_q.single    <= (cnt == '0);
      res_valid       <= 1'b1;
    end else if ((state == DONE) && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_min1_node = res_q.min1_node;
  assign res_min2_node = res_q.min2_node;
  assign res_min1_ed   = res_q.min1_ed;
  assign res_min2_ed   = res_q.min2_ed;
  assign res_single    = res_q.single;

endmodule

// File: tb/tb_ed_sweep_ctrl.sv
// Directed bench for ed_sweep_ctrl with a behavioural two-minimum finder.
module tb_ed_sweep_ctrl;

  localparam int BUDGET = 200;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_nodes;
  logic        busy;
  logic        cfg_err;
  logic        ed_req;
  logic [3:0]  ed_node;
  logic        ed_ack;
  logic [31:0] ed_value;
  logic        mf_enable;
  logic [31:0] mf_node;
  logic [31:0] mf_ed;
  logic [31:0] mf_min1_node;
  logic [31:0] mf_min2_node;
  logic [31:0] mf_min1_ed;
  logic [31:0] mf_min2_ed;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_min1_node;
  logic [31:0] res_min2_node;
  logic [31:0] res_min1_ed;
  logic [31:0] res_min2_ed;
  logic        res_single;

  logic [31:0] ed_tab [16];
  logic [31:0] last_fed;
  logic        fed_any;

  int checks;
  int failures;

  ed_sweep_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_nodes     (num_nodes),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .ed_req        (ed_req),
    .ed_node       (ed_node),
    .ed_ack        (ed_ack),
    .ed_value      (ed_value),
    .mf_enable     (mf_enable),
    .mf_node       (mf_node),
    .mf_ed         (mf_ed),
    .mf_min1_node  (mf_min1_node),
    .mf_min2_node  (mf_min2_node),
    .mf_min1_ed    (mf_min1_ed),
    .mf_min2_ed    (mf_min2_ed),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_min1_node (res_min1_node),
    .res_min2_node (res_min2_node),
    .res_min1_ed   (res_min1_ed),
    .res_min2_ed   (res_min2_ed),
    .res_single    (res_single)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-minimum finder: clears while disabled, takes each new node once;
  // strictly smaller ED displaces min1, equal-or-smaller than min2 replaces min2.
  always @(posedge clk) begin
    if (!mf_enable) begin
      mf_min1_node <= 32'hFFFF_FFFF;
      mf_min2_node <= 32'hFFFF_FFFF;
      mf_min1_ed   <= 32'hFFFF_FFFF;
      mf_min2_ed   <= 32'hFFFF_FFFF;
      fed_any      <= 1'b0;
    end else if (!fed_any || (mf_node != last_fed)) begin
      fed_any  <= 1'b1;
      last_fed <= mf_node;
      if (mf_ed < mf_min1_ed) begin
        mf_min2_node <= mf_min1_node;
        mf_min2_ed   <= mf_min1_ed;
        mf_min1_node <= mf_node;
        mf_min1_ed   <= mf_ed;
      end else if (mf_ed <= mf_min2_ed) begin
        mf_min2_node <= mf_node;
        mf_min2_ed   <= mf_ed;
      end
    end
  end

  // Driver: launch a sweep and answer ED requests after dly stall cycles.
  // lat = number of the rising edge (start-sampling edge is 0) at which
  // res_valid is first sampled high; 0 on timeout or abort.
  task automatic do_sweep(input int n, input int dly, input int abort_node,
                          output int lat, output int stall_err);
    int stall;
    logic [3:0] held;
    logic ack_prev;
    lat = 0;
    stall_err = 0;
    stall = 0;
    held = '0;
    num_nodes = 5'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      ack_prev = ed_ack;
      ed_ack = 1'b0;
      if (res_valid) begin
        lat = c;
        break;
      end
      if (ed_req && !ack_prev) begin
        if (int'(ed_node) == abort_node) break;
        if (stall > 0 && ed_node !== held) stall_err++;
        held = ed_node;
        if (stall == dly) begin
          ed_ack = 1'b1;
          ed_value = ed_tab[ed_node];
          stall = 0;
        end else begin
          stall++;
        end
      end
      @(negedge clk);
    end
    ed_ack = 1'b0;
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accept: res_valid=%0b busy=%0b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_nodes = '0;
    ed_ack = 1'b0;
    ed_value = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, cfg_err, ed_req, ed_node, mf_enable, mf_node, mf_ed, res_valid,
         res_min1_node, res_min2_node, res_min1_ed, res_min2_ed, res_single} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b req=%0b en=%0b valid=%0b node=%h ed=%h, required all 0",
               busy, ed_req, mf_enable, res_valid, mf_node, mf_ed);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, serr;
    ed_tab[0] = 32'd9; ed_tab[1] = 32'd3; ed_tab[2] = 32'd7; ed_tab[3] = 32'd5;
    do_sweep(4, 0, -1, lat, serr);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL basic_latency: edge=%0d, required 10", lat);
    end
    checks++;
    if ({res_min1_node, res_min1_ed, res_min2_node, res_min2_ed, res_single} !==
        {32'd1, 32'd3, 32'd3, 32'd5, 1'b0}) begin
      failures++;
      $display("FAIL basic_result: min1=(%0d,%0d) min2=(%0d,%0d) single=%0b, required (1,3) (3,5) 0",
               res_min1_node, res_min1_ed, res_min2_node, res_min2_ed, res_single);
    end
    accept_result();
  endtask

  task automatic test_ties();
    int lat, serr;
    ed_tab[0] = 32'd4; ed_tab[1] = 32'd4; ed_tab[2] = 32'd8;
    do_sweep(3, 0, -1, lat, serr);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL ties_latency: edge=%0d, required 8", lat);
    end
    checks++;
    if ({res_min1_node, res_min1_ed, res_min2_node, res_min2_ed} !==
        {32'd0, 32'd4, 32'd1, 32'd4}) begin
      failures++;
      $display("FAIL ties_result: min1=(%0d,%0d) min2=(%0d,%0d), required (0,4) (1,4)",
               res_min1_node, res_min1_ed, res_min2_node, res_min2_ed);
    end
    accept_result();
  endtask

  task automatic test_single();
    int lat, serr;
    ed_tab[0] = 32'd6;
    do_sweep(1, 0, -1, lat, serr);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL single_latency: edge=%0d, required 4", lat);
    end
    checks++;
    if ({res_min1_node, res_min1_ed, res_min2_ed, res_single} !==
        {32'd0, 32'd6, 32'hFFFF_FFFF, 1'b1}) begin
      failures++;
      $display("FAIL single_result: min1=(%0d,%0d) min2_ed=%h single=%0b, required (0,6) ffffffff 1",
               res_min1_node, res_min1_ed, res_min2_ed, res_single);
    end
    accept_result();
  endtask

  task automatic test_stall();
    int lat, serr;
    ed_tab[0] = 32'd10; ed_tab[1] = 32'd20;
    do_sweep(2, 3, -1, lat, serr);
    checks++;
    if (lat !== 12) begin
      failures++;
      $display("FAIL stall_latency: edge=%0d, required 12", lat);
    end
    checks++;
    if (serr !== 0) begin
      failures++;
      $display("FAIL stall_stable: node changes=%0d, required 0", serr);
    end
    checks++;
    if ({res_min1_node, res_min1_ed, res_min2_node, res_min2_ed} !==
        {32'd0, 32'd10, 32'd1, 32'd20}) begin
      failures++;
      $display("FAIL stall_result: min1=(%0d,%0d) min2=(%0d,%0d), required (0,10) (1,20)",
               res_min1_node, res_min1_ed, res_min2_node, res_min2_ed);
    end
    accept_result();
  endtask

  task automatic test_back_to_back();
    int lat, serr;
    ed_tab[0] = 32'd9; ed_tab[1] = 32'd3; ed_tab[2] = 32'd7; ed_tab[3] = 32'd5;
    do_sweep(4, 0, -1, lat, serr);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      num_nodes = 5'd4;
      @(negedge clk);
      checks++;
      if ({res_valid, busy, ed_req, cfg_err, res_min1_node, res_min1_ed, res_min2_node, res_min2_ed} !==
          {4'b1100, 32'd1, 32'd3, 32'd3, 32'd5}) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%0b busy=%0b req=%0b err=%0b min1=(%0d,%0d) min2=(%0d,%0d), required 1 1 0 0 (1,3) (3,5)",
                 i, res_valid, busy, ed_req, cfg_err, res_min1_node, res_min1_ed, res_min2_node, res_min2_ed);
      end
    end
    start = 1'b0;
    accept_result();
    ed_tab[0] = 32'd2; ed_tab[1] = 32'd1;
    do_sweep(2, 0, -1, lat, serr);
    checks++;
    if ({res_min1_node, res_min1_ed, res_min2_node, res_min2_ed} !==
        {32'd1, 32'd1, 32'd0, 32'd2}) begin
      failures++;
      $display("FAIL b2b_result: min1=(%0d,%0d) min2=(%0d,%0d), required (1,1) (0,2)",
               res_min1_node, res_min1_ed, res_min2_node, res_min2_ed);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_and_cfg();
    int lat, serr;
    ed_tab[0] = 32'd8; ed_tab[1] = 32'd6; ed_tab[2] = 32'd7; ed_tab[3] = 32'd9;
    do_sweep(4, 0, 2, lat, serr);
    checks++;
    if (ed_req !== 1'b1 || ed_node !== 4'd2 || mf_enable !== 1'b1) begin
      failures++;
      $display("FAIL mid_sweep_reach: req=%0b node=%0d en=%0b, required 1 2 1", ed_req, ed_node, mf_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cfg_err, ed_req, ed_node, mf_enable, mf_node, mf_ed, res_valid,
         res_min1_node, res_min2_node, res_min1_ed, res_min2_ed, res_single} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: busy=%0b req=%0b en=%0b valid=%0b node=%h, required all 0",
               busy, ed_req, mf_enable, res_valid, mf_node);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    num_nodes = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfg_zero: cfg_err=%0b busy=%0b, required 1 0", cfg_err, busy);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfg_pulse_end: cfg_err=%0b busy=%0b, required 0 0", cfg_err, busy);
    end
    num_nodes = 5'd17;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfg_over: cfg_err=%0b busy=%0b, required 1 0", cfg_err, busy);
    end
    @(negedge clk);
    do_sweep(3, 0, -1, lat, serr);
    checks++;
    if (lat !== 8 || {res_min1_node, res_min1_ed, res_min2_node, res_min2_ed} !==
        {32'd1, 32'd6, 32'd2, 32'd7}) begin
      failures++;
      $display("FAIL post_reset_result: edge=%0d min1=(%0d,%0d) min2=(%0d,%0d), required 8 (1,6) (2,7)",
               lat, res_min1_node, res_min1_ed, res_min2_node, res_min2_ed);
    end
    accept_result();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_ties();
    test_single();
    test_stall();
    test_back_to_back();
    test_reset_mid_and_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
